x_ibufds_deser: RTL

- Downstream consumer of the differential input buffer output: takes the single-ended recovered serial bit, synchronizes it into CLK, finds framing, and deserializes it into WIDTH-bit words.
- One bit is sampled per CLK cycle while EN=1.
- Frames are FRAME_LEN words long. Word 0 of each frame is SYNC_WORD; it is used for alignment and is never forwarded.
- Words 1..FRAME_LEN-1 are presented on DATA with a one-cycle VALID strobe.

---
 rtl/x_ibufds_deser.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/x_ibufds_deser.sv
`default_nettype none
// ============================================================================
//  Module   : x_ibufds_deser
//  Purpose  : Synchronises the recovered serial bit, finds frame alignment on
//             SYNC_WORD and emits LSB-first WIDTH-bit data words with a strobe.
//             Optional macro X_DESER_ERRCNT_EN enables the sync-miss counter.
//  Revision : 1.0 - initial release
// ============================================================================
module x_ibufds_deser #(
    parameter int              WIDTH     = 8,
    parameter logic [WIDTH-1:0] SYNC_WORD = 8'hBC,
    parameter int              FRAME_LEN = 16,
    parameter int              LOCK_CNT  = 2,
    parameter int              MISS_MAX  = 3
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic             I,
    input  logic             EN,
    output logic [WIDTH-1:0] DATA,
    output logic             VALID,
    output logic             LOCKED,
    output logic [15:0]      ERR_CNT
);

    localparam int c_BC_W   = $clog2(WIDTH);
    localparam int c_WC_W   = $clog2(FRAME_LEN);
    localparam int c_GOOD_W = $clog2(LOCK_CNT + 1);
    localparam int c_MISS_W = $clog2(MISS_MAX + 1);

    localparam logic [c_BC_W-1:0]   c_BC_MAX    = c_BC_W'(WIDTH - 1);
    localparam logic [c_BC_W-1:0]   c_BC_ONE    = c_BC_W'(1);
    localparam logic [c_WC_W-1:0]   c_WC_MAX    = c_WC_W'(FRAME_LEN - 1);
    localparam logic [c_WC_W-1:0]   c_WC_ONE    = c_WC_W'(1);
    localparam logic [c_GOOD_W-1:0] c_GOOD_ONE  = c_GOOD_W'(1);
    localparam logic [c_GOOD_W-1:0] c_GOOD_LAST = c_GOOD_W'(LOCK_CNT - 1);
    localparam logic [c_MISS_W-1:0] c_MISS_ONE  = c_MISS_W'(1);
    localparam logic [c_MISS_W-1:0] c_MISS_LAST = c_MISS_W'(MISS_MAX - 1);

    localparam logic [1:0] c_HUNT  = 2'd0;
    localparam logic [1:0] c_CHECK = 2'd1;
    localparam logic [1:0] c_LOCK  = 2'd2;

    logic             r_s1;
    logic             r_s2;
    logic [WIDTH-1:0] r_sh;
    logic [c_BC_W-1:0]   r_bc;
    logic [c_WC_W-1:0]   r_wc;
    logic [c_GOOD_W-1:0] r_good;
    logic [c_MISS_W-1:0] r_miss;
    logic [1:0]       r_state;
    logic [1:0]       w_state_next;
    logic [WIDTH-1:0] r_data;
    logic             r_valid;

    logic [WIDTH-1:0]  w_sh_next;
    logic [c_WC_W-1:0] w_wc_next;
    logic              w_match;
    logic              w_word_evt;
    logic              w_wc_zero;
    logic              w_sync_chk;
    logic              w_sync_ok;
    logic              w_sync_bad;
    logic              w_miss_last;

    // All decisions look at the word including the bit shifted in this cycle
    assign w_sh_next   = {r_s2, r_sh[WIDTH-1:1]};
    assign w_match     = (w_sh_next == SYNC_WORD);
    assign w_word_evt  = EN && (r_bc == c_BC_MAX);
    assign w_wc_zero   = (r_wc == '0);
    assign w_wc_next   = (r_wc == c_WC_MAX) ? '0 : r_wc + c_WC_ONE;
    assign w_sync_chk  = ((r_state == c_CHECK) || (r_state == c_LOCK)) && w_word_evt && w_wc_zero;
    assign w_sync_ok   = w_sync_chk && w_match;
    assign w_sync_bad  = w_sync_chk && !w_match;
    assign w_miss_last = (r_miss == c_MISS_LAST);

    // State register
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            r_state <= c_HUNT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_HUNT: begin
                if (EN && w_match) begin
                    w_state_next = (LOCK_CNT == 1) ? c_LOCK : c_CHECK;
                end
            end
            c_CHECK: begin
                if (w_sync_bad) begin
                    w_state_next = c_HUNT;
                end else if (w_sync_ok && (r_good == c_GOOD_LAST)) begin
                    w_state_next = c_LOCK;
                end
            end
            c_LOCK: begin
                if (w_sync_bad && w_miss_last) begin
                    w_state_next = c_HUNT;
                end
            end
            default: w_state_next = c_HUNT;
        endcase
    end

    // Output logic
    always_comb begin
        LOCKED = (r_state == c_LOCK);
        DATA   = r_data;
        VALID  = r_valid;
    end

    // Datapath: synchroniser keeps running while EN=0, everything else freezes
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_sh    <= '0;
            r_bc    <= '0;
            r_wc    <= '0;
            r_good  <= '0;
            r_miss  <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_s1    <= I;
            r_s2    <= r_s1;
            r_valid <= 1'b0;
            if (EN) begin
                r_sh <= w_sh_next;
                r_bc <= (r_bc == c_BC_MAX) ? '0 : r_bc + c_BC_ONE;
                if (w_word_evt) begin
                    r_wc <= w_wc_next;
                end
                case (r_state)
                    c_HUNT: begin
                        if (w_match) begin
                            r_bc   <= '0;
                            r_wc   <= c_WC_ONE;
                            r_good <= c_GOOD_ONE;
                        end
                    end
                    c_CHECK: begin
                        if (w_sync_ok) begin
                            r_good <= r_good + c_GOOD_ONE;
                        end else if (w_sync_bad) begin
                            r_good <= '0;
                        end
                    end
                    c_LOCK: begin
                        if (w_word_evt && !w_wc_zero) begin
                            r_data  <= w_sh_next;
                            r_valid <= 1'b1;
                        end else if (w_sync_ok) begin
                            r_miss <= '0;
                        end else if (w_sync_bad) begin
                            if (w_miss_last) begin
                                r_bc   <= '0;
                                r_wc   <= '0;
                                r_miss <= '0;
                            end else begin
                                r_miss <= r_miss + c_MISS_ONE;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef X_DESER_ERRCNT_EN
    logic [15:0] r_err_cnt;

    // Saturating count of every sync-word mismatch seen while aligned or checking
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            r_err_cnt <= 16'h0000;
        end else if (w_sync_bad && (r_err_cnt != 16'hFFFF)) begin
            r_err_cnt <= r_err_cnt + 16'h0001;
        end
    end

    assign ERR_CNT = r_err_cnt;
`else
    assign ERR_CNT = 16'h0000;
`endif

endmodule
`default_nettype wire
